top: RTL and testbench

Streaming fixed-point arithmetic block computing q = ((a − b)·(1 + 3c) − 4d) / 2 on DATA_WIDTH-bit unsigned operands with per-operand valid strobes. It is the top-level compute unit of the design. It is fully pipelined and accepts one operand set per clock. Results emerge in order with a valid strobe after a fixed latency.

---
 rtl/top_if.sv | 44 ++++
 rtl/top.sv | 154 +++++++++++++++
 tb/tb_top.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/top_if.sv
// Operand/result bundle for the streaming arithmetic unit.
// The master drives operands with per-operand valid strobes; the slave returns q with its strobe.
interface top_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0] a_i;
  logic [DATA_WIDTH-1:0] b_i;
  logic [DATA_WIDTH-1:0] c_i;
  logic [DATA_WIDTH-1:0] d_i;
  logic                  a_valid_i;
  logic                  b_valid_i;
  logic                  c_valid_i;
  logic                  d_valid_i;
  logic [DATA_WIDTH-1:0] q_o;
  logic                  q_valid_o;

  modport master (
    output a_i,
    output b_i,
    output c_i,
    output d_i,
    output a_valid_i,
    output b_valid_i,
    output c_valid_i,
    output d_valid_i,
    input  q_o,
    input  q_valid_o
  );

  modport slave (
    input  a_i,
    input  b_i,
    input  c_i,
    input  d_i,
    input  a_valid_i,
    input  b_valid_i,
    input  c_valid_i,
    input  d_valid_i,
    output q_o,
    output q_valid_o
  );

endinterface

// File: rtl/top.sv
// Streaming unsigned fixed-point unit: q = ((a - b) * (1 + 3c) - 4d) >> 1, all modulo 2^DATA_WIDTH.
// Operands arrive independently and are gathered in one-entry holding registers; a complete
// set launches into a 3-edge pipeline (S1, S2, S3 -> output register). No backpressure.
module top #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic   clk_i,
  input  logic   artsn_i,
  top_if.slave   bus
);

  typedef logic [DATA_WIDTH-1:0] word_t;

  localparam word_t One = word_t'(1);

  // Operand index order: 0 = a, 1 = b, 2 = c, 3 = d.
  word_t [3:0] in_data;
  logic  [3:0] in_valid;

  assign in_data  = {bus.d_i, bus.c_i, bus.b_i, bus.a_i};
  assign in_valid = {bus.d_valid_i, bus.c_valid_i, bus.b_valid_i, bus.a_valid_i};

  // Holding registers and their held flags.
  word_t [3:0] hold_q;
  logic  [3:0] held_q;

  logic  [3:0] avail;
  logic        launch;
  word_t [3:0] opnd;

  // Launch when every operand is either arriving now or already held; fresh data wins.
  always_comb begin
    avail  = in_valid | held_q;
    launch = &avail;
    opnd   = hold_q;
    for (int i = 0; i < 4; i++) begin
      if (in_valid[i]) begin
        opnd[i] = in_data[i];
      end
    end
  end

  // Capture lone operands (last write wins); a launch consumes everything held.
  always_ff @(posedge clk_i or negedge artsn_i) begin
    if (!artsn_i) begin
      hold_q <= '0;
      held_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (launch) begin
          held_q[i] <= 1'b0;
        end else if (in_valid[i]) begin
          hold_q[i] <= in_data[i];
          held_q[i] <= 1'b1;
        end
      end
    end
  end

  // Stage 1 next-state: difference, multiplier 1 + 3c, and the scaled subtrahend.
  word_t diff_d;
  word_t k_d;
  word_t d4_d;

  always_comb begin
    diff_d = opnd[0] - opnd[1];
    k_d    = opnd[2] + (opnd[2] << 1) + One;
    d4_d   = opnd[3] << 2;
  end

  word_t diff_q;
  word_t k_q;
  word_t d4_s1_q;
  logic  v1_q;

  // S1 register.
  always_ff @(posedge clk_i or negedge artsn_i) begin
    if (!artsn_i) begin
      diff_q  <= '0;
      k_q     <= '0;
      d4_s1_q <= '0;
      v1_q    <= 1'b0;
    end else begin
      diff_q  <= diff_d;
      k_q     <= k_d;
      d4_s1_q <= d4_d;
      v1_q    <= launch;
    end
  end

  // Product truncated to the operand width.
  word_t prod_d;

  always_comb begin
    prod_d = diff_q * k_q;
  end

  word_t prod_q;
  word_t d4_s2_q;
  logic  v2_q;

  // S2 register; 4d rides along for the subtraction in S3.
  always_ff @(posedge clk_i or negedge artsn_i) begin
    if (!artsn_i) begin
      prod_q  <= '0;
      d4_s2_q <= '0;
      v2_q    <= 1'b0;
    end else begin
      prod_q  <= prod_d;
      d4_s2_q <= d4_s1_q;
      v2_q    <= v1_q;
    end
  end

  word_t s_d;

  always_comb begin
    s_d = prod_q - d4_s2_q;
  end

  word_t s_q;
  logic  v3_q;

  // S3 register.
  always_ff @(posedge clk_i or negedge artsn_i) begin
    if (!artsn_i) begin
      s_q  <= '0;
      v3_q <= 1'b0;
    end else begin
      s_q  <= s_d;
      v3_q <= v2_q;
    end
  end

  word_t q_q;
  logic  q_valid_q;

  // Output register: q holds its last result between strobes.
  always_ff @(posedge clk_i or negedge artsn_i) begin
    if (!artsn_i) begin
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      if (v3_q) begin
        q_q <= s_q >> 1;
      end
      q_valid_q <= v3_q;
    end
  end

  assign bus.q_o       = q_q;
  assign bus.q_valid_o = q_valid_q;

endmodule

// File: tb/tb_top.sv
// Directed bench for top: table-driven vectors plus hand-written multi-cycle sequences.
module tb_top;

  logic clk = 1'b0;
  logic artsn;

  top_if #(.DATA_WIDTH(32)) bus ();

  top #(.DATA_WIDTH(32)) dut (
    .clk_i   (clk),
    .artsn_i (artsn),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] q;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] last_q   = 32'h0;
  int          exp_due[$];
  logic [31:0] exp_val[$];

  function automatic logic [31:0] ref_q(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
    logic [31:0] diff;
    logic [31:0] k;
    logic [31:0] prod;
    logic [31:0] s;
    diff = a - b;
    k    = 32'd1 + 32'd3 * c;
    prod = diff * k;
    s    = prod - d * 32'd4;
    return s / 32'd2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic va, input logic vb, input logic vc, input logic vd,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    bus.a_valid_i = va;
    bus.b_valid_i = vb;
    bus.c_valid_i = vc;
    bus.d_valid_i = vd;
    bus.a_i       = a;
    bus.b_i       = b;
    bus.c_i       = c;
    bus.d_i       = d;
  endtask

  // One rising edge; optionally schedule an expected result 3 edges out, then check outputs.
  task automatic tick(input bit launch, input logic [31:0] exp);
    @(posedge clk);
    cyc++;
    if (launch) begin
      exp_due.push_back(cyc + 3);
      exp_val.push_back(exp);
    end
    #1;
    if (exp_due.size() != 0 && exp_due[0] == cyc) begin
      check("q_valid pulse", {31'b0, bus.q_valid_o}, 32'd1);
      check("q value", bus.q_o, exp_val[0]);
      last_q = exp_val[0];
      void'(exp_due.pop_front());
      void'(exp_val.pop_front());
    end else begin
      check("q_valid idle", {31'b0, bus.q_valid_o}, 32'd0);
      check("q hold", bus.q_o, last_q);
    end
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d, input logic [31:0] q);
    drive(1'b1, 1'b1, 1'b1, 1'b1, a, b, c, d);
    tick(1'b1, q);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D, 32'h0BAD_0BAD);
    tick(1'b0, 32'h0);
  endtask

  vec_t vecs[5];

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] rc;
    logic [31:0] rd;

    vecs[0] = '{a: 32'd10,         b: 32'd4,  c: 32'd2, d: 32'd1, q: 32'd19};
    vecs[1] = '{a: 32'd4,          b: 32'd10, c: 32'd0, d: 32'd0, q: 32'h7FFF_FFFD};
    vecs[2] = '{a: 32'd0,          b: 32'd0,  c: 32'd0, d: 32'd1, q: 32'h7FFF_FFFE};
    vecs[3] = '{a: 32'h8000_0000,  b: 32'd0,  c: 32'd1, d: 32'd0, q: 32'h0};
    vecs[4] = '{a: 32'd100,        b: 32'd1,  c: 32'd5, d: 32'd3, q: 32'd786};

    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    artsn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset q", bus.q_o, 32'h0);
    check("reset q_valid", {31'b0, bus.q_valid_o}, 32'd0);
    @(negedge clk);
    artsn = 1'b1;

    // Single set, then q holds 19 with no further strobe.
    apply(vecs[0].a, vecs[0].b, vecs[0].c, vecs[0].d, vecs[0].q);
    repeat (6) idle();

    // Table vectors, each isolated.
    for (int i = 1; i < 5; i++) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].q);
      repeat (4) idle();
    end

    // Table vectors back-to-back.
    for (int i = 0; i < 5; i++) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].q);
    end
    repeat (4) idle();

    // Five random sets on consecutive cycles.
    for (int i = 0; i < 5; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = $urandom;
      rd = $urandom;
      apply(ra, rb, rc, rd, ref_q(ra, rb, rc, rd));
    end
    // Five random sets with random 0/1 gaps.
    for (int i = 0; i < 5; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = $urandom;
      rd = $urandom;
      apply(ra, rb, rc, rd, ref_q(ra, rb, rc, rd));
      if ($urandom_range(0, 1) == 1) idle();
    end
    repeat (4) idle();

    // Staggered: a,b at edge 0, c at edge 2, d at edge 4 -> result at edge 7.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd10, 32'd4, 32'd77, 32'd77);
    tick(1'b0, 32'h0);
    idle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd55, 32'd55, 32'd2, 32'd77);
    tick(1'b0, 32'h0);
    idle();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd55, 32'd55, 32'd55, 32'd1);
    tick(1'b1, 32'd19);
    repeat (5) idle();

    // Overwrite: a=99 then a=10 before b,c,d arrive.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd99, 32'd0, 32'd0, 32'd0);
    tick(1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd10, 32'd0, 32'd0, 32'd0);
    tick(1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'd99, 32'd4, 32'd2, 32'd1);
    tick(1'b1, 32'd19);
    repeat (5) idle();

    // Mid-flight reset: two sets in flight and a held a; all must vanish.
    apply(32'd7, 32'd2, 32'd3, 32'd0, ref_q(32'd7, 32'd2, 32'd3, 32'd0));
    apply(32'd9, 32'd1, 32'd1, 32'd1, ref_q(32'd9, 32'd1, 32'd1, 32'd1));
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd50, 32'd0, 32'd0, 32'd0);
    tick(1'b0, 32'h0);
    #1;
    artsn = 1'b0;
    #1;
    check("async reset q", bus.q_o, 32'h0);
    check("async reset q_valid", {31'b0, bus.q_valid_o}, 32'd0);
    exp_due.delete();
    exp_val.delete();
    last_q = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    artsn = 1'b1;
    // Only b,c,d arrive; a held before reset must not complete the set.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'd0, 32'd4, 32'd2, 32'd1);
    tick(1'b0, 32'h0);
    repeat (6) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
